memory_arbiter: RTL and testbench

Memory-side responder for the `caches_if` bus that the icache and dcache drive. It accepts instruction-fetch and data read/write requests, arbitrates them onto a single-port RAM interface with variable latency, and returns `iwait`/`dwait` together with load data. Data requests have priority over instruction requests. A fairness bit guarantees that a pending fetch is served immediately after any data access, and a watchdog flags RAM accesses that never complete.

---
 rtl/memory_arbiter_pkg.sv | 17 +
 rtl/memory_arbiter_if.sv | 32 +++
 rtl/memory_arbiter_watchdog_counter.sv | 46 ++++
 rtl/memory_arbiter.sv | 129 ++++++++++++
 tb/tb_memory_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter slice.
//   word_t      : 32-bit bus word
//   ARB_CNT_W   : width of the grant watchdog counter
//   arb_state_t : arbiter FSM states
package memory_arbiter_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned ARB_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        DGNT,
        IGNT
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// caches_if: request/response bundle between the icache/dcache and memory.
//   iREN, iaddr          : instruction fetch request
//   dREN, dWEN, daddr,
//   dstore               : data read/write request
//   iwait, dwait         : low for one cycle when the access completes
//   iload, dload         : load data, valid while the matching wait is low
// Modports: cache (request driver), memory (responder).
interface caches_if;
    import memory_arbiter_pkg::*;

    logic  iREN;
    logic  dREN;
    logic  dWEN;
    word_t iaddr;
    word_t daddr;
    word_t dstore;
    logic  iwait;
    logic  dwait;
    word_t iload;
    word_t dload;

    modport cache (
        output iREN, dREN, dWEN, iaddr, daddr, dstore,
        input  iwait, dwait, iload, dload
    );

    modport memory (
        input  iREN, dREN, dWEN, iaddr, daddr, dstore,
        output iwait, dwait, iload, dload
    );

endinterface

// File: rtl/memory_arbiter_watchdog_counter.sv
// watchdog_counter: saturating cycle counter with a sticky limit flag.
//   clk, rst : clock, synchronous active-high reset
//   clear    : zero the counter (takes priority over enable)
//   enable   : count one cycle
//   flag     : sticky, sets when the counter reaches LIMIT, clears on rst
module watchdog_counter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic flag
);

    localparam logic [ARB_CNT_W-1:0] LIMIT_C = ARB_CNT_W'(LIMIT);

    logic [ARB_CNT_W-1:0] count;
    logic [ARB_CNT_W-1:0] count_next;

    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (enable && (count != '1)) begin
            count_next = count + 1'b1;
        end
    end

    // Flag is set from the next count so it rises on the same edge the
    // counter reaches the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            flag  <= 1'b0;
        end else begin
            count <= count_next;
            if (count_next == LIMIT_C) begin
                flag <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: arbitrates icache and dcache requests onto one RAM port.
//   CLK, RST   : clock, synchronous active-high reset
//   cif        : caches_if.memory request/response bundle
//   ramREN     : RAM read strobe
//   ramWEN     : RAM write strobe
//   ramaddr    : RAM word address
//   ramstore   : RAM write data
//   ramload    : RAM read data, valid with ram_ready
//   ram_ready  : RAM completes the presented access this cycle
//   ram_err    : sticky flag, a grant waited TIMEOUT cycles
// Data beats instruction unless the previous completed access was data.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic     CLK,
    input  logic     RST,
    caches_if.memory cif,
    output logic     ramREN,
    output logic     ramWEN,
    output word_t    ramaddr,
    output word_t    ramstore,
    input  word_t    ramload,
    input  logic     ram_ready,
    output logic     ram_err
);

    arb_state_t state;
    arb_state_t state_next;
    logic       last_d;
    logic       dreq;
    logic       d_done;
    logic       i_done;

    assign dreq   = cif.dREN | cif.dWEN;
    assign d_done = (state == DGNT) && dreq && ram_ready;
    assign i_done = (state == IGNT) && cif.iREN && ram_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            last_d <= 1'b0;
        end else begin
            state <= state_next;
            if (d_done) begin
                last_d <= 1'b1;
            end else if (i_done) begin
                last_d <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (dreq && !(cif.iREN && last_d)) begin
                    state_next = DGNT;
                end else if (cif.iREN) begin
                    state_next = IGNT;
                end
            end
            DGNT: begin
                if (!dreq || ram_ready) begin
                    state_next = IDLE;
                end
            end
            IGNT: begin
                if (!cif.iREN || ram_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Completion pulses are masked during reset so a mid-grant reset never
    // shows the cache a wait-low.
    always_comb begin
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        cif.iwait = 1'b1;
        cif.dwait = 1'b1;
        cif.iload = '0;
        cif.dload = '0;
        unique case (state)
            DGNT: begin
                if (dreq) begin
                    ramaddr = cif.daddr;
                    if (cif.dWEN) begin
                        ramWEN   = 1'b1;
                        ramstore = cif.dstore;
                    end else begin
                        ramREN = 1'b1;
                    end
                    if (ram_ready && !RST) begin
                        cif.dwait = 1'b0;
                        cif.dload = cif.dWEN ? '0 : ramload;
                    end
                end
            end
            IGNT: begin
                if (cif.iREN) begin
                    ramREN  = 1'b1;
                    ramaddr = cif.iaddr;
                    if (ram_ready && !RST) begin
                        cif.iwait = 1'b0;
                        cif.iload = ramload;
                    end
                end
            end
            default: ;
        endcase
    end

    watchdog_counter #(
        .LIMIT (TIMEOUT)
    ) u_watchdog (
        .clk    (CLK),
        .rst    (RST),
        .clear  (state == IDLE),
        .enable ((state != IDLE) && !ram_ready),
        .flag   (ram_err)
    );

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: scoreboard bench for memory_arbiter (TIMEOUT=4).
// Expected load words are queued when a completion is driven and popped by
// a negedge monitor whenever iwait/dwait drops.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    logic  CLK = 1'b0;
    logic  RST;
    logic  ramREN;
    logic  ramWEN;
    word_t ramaddr;
    word_t ramstore;
    word_t ramload;
    logic  ram_ready;
    logic  ram_err;

    caches_if cif ();

    memory_arbiter #(
        .TIMEOUT (4)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .cif       (cif),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ram_ready (ram_ready),
        .ram_err   (ram_err)
    );

    always #5 CLK = ~CLK;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;
    word_t       iq[$];
    word_t       dq[$];

    task automatic check_eq(input string tag, input word_t act, input word_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    // {iwait, dwait, ramREN, ramWEN, ram_err} plus zero bus values
    task automatic chk_idle(input string tag, input logic err);
        check_eq({tag, "_flags"},
                 32'({cif.iwait, cif.dwait, ramREN, ramWEN, ram_err}),
                 32'({4'b1100, err}));
        check_eq({tag, "_addr"}, ramaddr, '0);
        check_eq({tag, "_store"}, ramstore, '0);
    endtask

    always @(negedge CLK) begin
        if (cif.iwait === 1'b0) begin
            if (iq.size() == 0) check_eq("iwait_unexpected", 32'(cif.iwait), 32'd1);
            else                check_eq("iload", cif.iload, iq.pop_front());
        end
        if (cif.dwait === 1'b0) begin
            if (dq.size() == 0) check_eq("dwait_unexpected", 32'(cif.dwait), 32'd1);
            else                check_eq("dload", cif.dload, dq.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got %0d checks expected completion", n_checks);
        $fatal(1);
    end

    initial begin
        RST       = 1'b1;
        cif.iREN  = 1'b0;
        cif.dREN  = 1'b0;
        cif.dWEN  = 1'b0;
        cif.iaddr = '0;
        cif.daddr = '0;
        cif.dstore = '0;
        ram_ready = 1'b0;
        ramload   = '0;
        repeat (2) cyc();
        RST = 1'b0;

        // idle after reset
        for (int i = 0; i < 10; i++) begin
            smp(); chk_idle("reset_idle", 1'b0); cyc();
        end

        // instruction fetch, ready three cycles after grant
        cif.iREN  = 1'b1;
        cif.iaddr = 32'h100;
        smp(); check_eq("t2_req_cycle_ren", 32'(ramREN), 32'd0); cyc();
        for (int i = 0; i < 3; i++) begin
            smp();
            check_eq("t2_wait_ren", 32'({ramREN, ramWEN, cif.iwait}), 32'b101);
            check_eq("t2_wait_addr", ramaddr, 32'h100);
            cyc();
        end
        ram_ready = 1'b1;
        ramload   = 32'hDEADBEEF;
        iq.push_back(32'hDEADBEEF);
        smp(); check_eq("t2_done_ren", 32'(ramREN), 32'd1); cyc();
        ram_ready = 1'b0;
        cif.iREN  = 1'b0;
        smp(); chk_idle("t2_after", 1'b0); cyc();

        // simultaneous write and fetch, last_d=0 so data first
        cif.dWEN   = 1'b1;
        cif.daddr  = 32'h200;
        cif.dstore = 32'h12345678;
        cif.iREN   = 1'b1;
        cif.iaddr  = 32'h300;
        smp(); check_eq("t3_idle_strobes", 32'({ramREN, ramWEN}), 32'd0); cyc();
        ram_ready = 1'b1;
        ramload   = 32'hBAD0BAD0;
        dq.push_back(32'h0);
        smp();
        check_eq("t3_wr_strobes", 32'({ramREN, ramWEN}), 32'b01);
        check_eq("t3_wr_addr", ramaddr, 32'h200);
        check_eq("t3_wr_store", ramstore, 32'h12345678);
        cyc();
        // data read still pending, fairness must pick the fetch
        ram_ready  = 1'b0;
        cif.dWEN   = 1'b0;
        cif.dREN   = 1'b1;
        cif.daddr  = 32'h204;
        smp(); check_eq("t3_gap_ren", 32'(ramREN), 32'd0); cyc();
        ram_ready = 1'b1;
        ramload   = 32'hCAFEF00D;
        iq.push_back(32'hCAFEF00D);
        smp();
        check_eq("t3_fair_strobes", 32'({ramREN, ramWEN}), 32'b10);
        check_eq("t3_fair_addr", ramaddr, 32'h300);
        check_eq("t3_fair_dwait", 32'(cif.dwait), 32'd1);
        cyc();
        ram_ready = 1'b0;
        cif.iREN  = 1'b0;
        smp(); check_eq("t3_gap2_dwait", 32'(cif.dwait), 32'd1); cyc();
        ram_ready = 1'b1;
        ramload   = 32'hA5A50001;
        dq.push_back(32'hA5A50001);
        smp(); check_eq("t3_rd_addr", ramaddr, 32'h204); cyc();
        ram_ready = 1'b0;
        cif.dREN  = 1'b0;
        smp(); chk_idle("t3_after", 1'b0); cyc();

        // data read aborted in its third grant cycle (last_d is 1 here)
        cif.dREN  = 1'b1;
        cif.daddr = 32'h400;
        cyc();
        for (int i = 0; i < 2; i++) begin
            smp(); check_eq("t4_grant_addr", ramaddr, 32'h400); cyc();
        end
        cif.dREN  = 1'b0;
        ram_ready = 1'b1;
        ramload   = 32'h0BADF00D;
        smp();
        check_eq("t4_abort_strobes", 32'({ramREN, ramWEN, cif.dwait}), 32'b001);
        cyc();
        ram_ready = 1'b0;
        smp(); chk_idle("t4_idle", 1'b0); cyc();
        // last_d still 1: both requesters -> fetch wins
        cif.iREN  = 1'b1;
        cif.iaddr = 32'h500;
        cif.dREN  = 1'b1;
        cif.daddr = 32'h504;
        cyc();
        ram_ready = 1'b1;
        ramload   = 32'h11112222;
        iq.push_back(32'h11112222);
        smp(); check_eq("t4_lastd_addr", ramaddr, 32'h500); cyc();
        ram_ready = 1'b0;
        cif.iREN  = 1'b0;
        cyc();
        ram_ready = 1'b1;
        ramload   = 32'h33334444;
        dq.push_back(32'h33334444);
        smp(); check_eq("t4_data_addr", ramaddr, 32'h504); cyc();
        ram_ready = 1'b0;
        cif.dREN  = 1'b0;
        cyc();

        // watchdog: write stalls four cycles
        cif.dWEN   = 1'b1;
        cif.daddr  = 32'h600;
        cif.dstore = 32'h55AA55AA;
        cyc();
        for (int i = 0; i < 4; i++) begin
            smp(); check_eq("t5_err_before", 32'(ram_err), 32'd0); cyc();
        end
        smp(); check_eq("t5_err_set", 32'(ram_err), 32'd1);
        check_eq("t5_still_granted", 32'(ramWEN), 32'd1);
        cyc();
        ram_ready = 1'b1;
        dq.push_back(32'h0);
        cyc();
        ram_ready = 1'b0;
        cif.dWEN  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            smp(); chk_idle("t5_sticky", 1'b1); cyc();
        end

        // reset during a completing fetch
        cif.iREN  = 1'b1;
        cif.iaddr = 32'h700;
        cyc();
        ram_ready = 1'b1;
        ramload   = 32'h77777777;
        RST       = 1'b1;
        smp(); check_eq("t6_rst_iwait", 32'(cif.iwait), 32'd1); cyc();
        RST       = 1'b0;
        ram_ready = 1'b0;
        cif.iREN  = 1'b0;
        smp();
        chk_idle("t6_after_rst", 1'b0);
        check_eq("t6_iload", cif.iload, '0);
        check_eq("t6_dload", cif.dload, '0);
        cyc();

        check_eq("iq_drained", 32'(iq.size()), 32'd0);
        check_eq("dq_drained", 32'(dq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
